// File: rtl/dac_pattern_player.sv
// dac_pattern_player: byte-command sample RAM player for a DAC bus; optional trigger start under DAC_PLAYER_TRIG_EN
module dac_pattern_player #(
  parameter int DATA_W = 15,
  parameter int ADR_W  = 10,
  parameter int DIV_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              new_rx_data,
  output logic [7:0]        tx_data,
  output logic              new_tx_data,
  input  logic              tx_busy,
`ifdef DAC_PLAYER_TRIG_EN
  input  logic              trig,
`endif
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_strobe,
  output logic              playing,
  output logic              play_done
);
  localparam int DEPTH = 2**ADR_W;
  typedef enum logic [2:0] {S_IDLE, S_PAY, S_SEND, S_HI, S_LO} st_t;
  st_t st_q, st_d;
  logic [7:0] op_q, op_d, ex_op;
  logic [2:0] idx_q, idx_d;
  logic [31:0] val_q, val_d;
  logic [23:0] rep_q, rep_d, status;
  logic [1:0] rc_q, rc_d;
  logic ex, armed, start, tick, unused;
  logic [ADR_W-1:0] wr_ptr_q, end_adr_q, play_ptr_q;
  logic [DIV_W-1:0] div_q, cnt_q;
  logic [15:0] ptr16;
  logic [DATA_W-1:0] dac_data_q;
  logic loop_q, playing_q, dac_strobe_q, play_done_q;
  logic [DATA_W-1:0] mem [DEPTH];
  function automatic logic [2:0] plen(input logic [7:0] op);
    return op == 8'h04 ? 3'd4 : op == 8'h05 ? 3'd1 :
           (op inside {8'h01, 8'h02, 8'h03, 8'h08}) ? 3'd2 : 3'd0;
  endfunction
  assign ptr16 = 16'(play_ptr_q);
  assign status = {ptr16, 5'b0, armed, loop_q, playing_q};
  assign tx_data = rep_q[7:0];
  assign dac_data = dac_data_q;
  assign dac_strobe = dac_strobe_q;
  assign playing = playing_q;
  assign play_done = play_done_q;
  assign tick = playing_q && cnt_q == '0;
  assign unused = ^val_d;
  // parser and reply state register
  always_ff @(posedge clk)
    if (rst) begin
      st_q <= S_IDLE;
      op_q <= '0;
      idx_q <= '0;
      val_q <= '0;
      rep_q <= '0;
      rc_q <= '0;
    end else begin
      st_q <= st_d;
      op_q <= op_d;
      idx_q <= idx_d;
      val_q <= val_d;
      rep_q <= rep_d;
      rc_q <= rc_d;
    end
  // opcode/payload collection, command execute strobe, and byte-by-byte status reply
  always_comb begin
    st_d = st_q;
    op_d = op_q;
    idx_d = idx_q;
    val_d = val_q;
    rep_d = rep_q;
    rc_d = rc_q;
    ex = 1'b0;
    new_tx_data = 1'b0;
    ex_op = st_q == S_IDLE ? rx_data : op_q;
    if (st_q == S_IDLE && new_rx_data) begin
      op_d = rx_data;
      idx_d = '0;
      val_d = '0;
      rep_d = status;
      rc_d = 2'd2;
      ex = rx_data == 8'h06;
      st_d = rx_data == 8'h07 ? S_SEND : plen(rx_data) != 3'd0 ? S_PAY : S_IDLE;
    end else if (st_q == S_PAY && new_rx_data) begin
      val_d = val_q | (32'(rx_data) << {idx_q[1:0], 3'b000});
      idx_d = idx_q + 3'd1;
      ex = idx_d == plen(op_q);
      st_d = ex ? S_IDLE : S_PAY;
    end else if (st_q == S_SEND && !tx_busy) begin
      new_tx_data = 1'b1;
      rep_d = rep_q >> 8;
      st_d = S_HI;
    end else if (st_q == S_HI && tx_busy) begin
      st_d = S_LO;
    end else if (st_q == S_LO && !tx_busy) begin
      rc_d = rc_q - 2'd1;
      st_d = rc_q == 2'd0 ? S_IDLE : S_SEND;
    end
  end
`ifdef DAC_PLAYER_TRIG_EN
  logic [2:0] trig_q;
  logic armed_q;
  // two-flop trigger synchroniser plus edge history; PLAY arms, STOP or a start disarms
  always_ff @(posedge clk)
    if (rst) begin
      trig_q <= '0;
      armed_q <= 1'b0;
    end else begin
      trig_q <= {trig_q[1:0], trig};
      armed_q <= ex && ex_op == 8'h05 ? 1'b1 : (ex && ex_op == 8'h06) || start ? 1'b0 : armed_q;
    end
  assign armed = armed_q;
  assign start = armed_q && trig_q[1] && !trig_q[2];
`else
  assign armed = 1'b0;
  assign start = ex && ex_op == 8'h05;
`endif
  // configuration registers written by commands
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr_q <= '0;
      end_adr_q <= '0;
      div_q <= '0;
    end else if (ex) begin
      wr_ptr_q <= ex_op == 8'h01 ? val_d[ADR_W-1:0] : ex_op == 8'h02 ? wr_ptr_q + ADR_W'(1) : wr_ptr_q;
      end_adr_q <= ex_op == 8'h03 ? val_d[ADR_W-1:0] : end_adr_q;
      div_q <= ex_op == 8'h04 ? val_d[DIV_W-1:0] : div_q;
    end
  // sample RAM write port; contents survive reset
  always_ff @(posedge clk)
    if (ex && ex_op == 8'h02) mem[wr_ptr_q] <= val_d[DATA_W-1:0];
  // playback engine: STOP beats restart beats static write beats sample tick
  always_ff @(posedge clk)
    if (rst) begin
      loop_q <= 1'b0;
      playing_q <= 1'b0;
      play_ptr_q <= '0;
      cnt_q <= '0;
      dac_data_q <= '0;
      dac_strobe_q <= 1'b0;
      play_done_q <= 1'b0;
    end else begin
      dac_strobe_q <= 1'b0;
      play_done_q <= 1'b0;
      if (ex && ex_op == 8'h05) loop_q <= val_d[0];
      if (ex && ex_op == 8'h06) begin
        playing_q <= 1'b0;
      end else if (start) begin
        playing_q <= 1'b1;
        play_ptr_q <= '0;
        cnt_q <= '0;
      end else if (ex && ex_op == 8'h08 && !playing_q) begin
        dac_data_q <= val_d[DATA_W-1:0];
        dac_strobe_q <= 1'b1;
      end else if (tick) begin
        dac_data_q <= mem[play_ptr_q];
        dac_strobe_q <= 1'b1;
        cnt_q <= div_q;
        if (play_ptr_q == end_adr_q) begin
          playing_q <= loop_q;
          play_done_q <= !loop_q;
          play_ptr_q <= loop_q ? '0 : play_ptr_q;
        end else begin
          play_ptr_q <= play_ptr_q + ADR_W'(1);
        end
      end else if (playing_q) begin
        cnt_q <= cnt_q - DIV_W'(1);
      end
    end
endmodule
